// File: rtl/rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_loader_pkg
// Shared definitions for the framed ROM image loader.
//   - state_t              : loader FSM states
//   - SYNC_BYTE_DEFAULT    : default frame start marker
//   - LEN_ZERO_MEANS_256   : a LEN byte of 0 encodes a 256-byte payload
//   - len_to_count()       : converts the LEN byte to a 9-bit remaining count
// No ports (package).
// -----------------------------------------------------------------------------
package rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT  = 8'hA5;
  localparam bit         LEN_ZERO_MEANS_256 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AHI,
    ST_ALO,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_t;

  // The count needs nine bits so that a LEN of 0 can be held as 256.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    if (LEN_ZERO_MEANS_256 && (len == 8'h00)) begin
      return 9'd256;
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/rom_image_loader_if.sv
// -----------------------------------------------------------------------------
// rom_image_loader_if
// Groups the byte-stream input handshake and the ROM write port / status
// outputs of the loader.
//   in_valid/in_data/in_ready : upstream byte stream (valid/ready)
//   wr_en/wr_addr/wr_data     : ROM write port
//   frame_ok/frame_err        : one-cycle frame result pulses
//   busy, ok_count            : frame-in-progress flag, saturating OK counter
// Modports: master = loader side, slave = host / stream source side.
// -----------------------------------------------------------------------------
interface rom_image_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_ok;
  logic              frame_err;
  logic              busy;
  logic [7:0]        ok_count;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data,
    output frame_ok, frame_err, busy, ok_count
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data,
    input  frame_ok, frame_err, busy, ok_count
  );

endinterface

// File: rtl/rom_loader_csum.sv
// -----------------------------------------------------------------------------
// rom_loader_csum
// 8-bit running-sum accumulator (modulo 256) with synchronous clear and add.
// Clear has priority over add.
//   clk     in  clock
//   rst     in  asynchronous active-high reset
//   i_clear in  zero the sum
//   i_add   in  add i_byte to the sum
//   i_byte  in  byte to add
//   o_sum   out current sum
// -----------------------------------------------------------------------------
module rom_loader_csum
  import rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/rom_image_loader.sv
// -----------------------------------------------------------------------------
// rom_image_loader
// Framed byte-stream loader producing a ROM write port. Hunts for SYNC_BYTE,
// takes a 16-bit start address and a length (0 = 256), writes the payload to
// consecutive addresses (wrapping modulo 2^ADDR_W) and reports the frame result.
//
// Frame: SYNC, ADDR_HI, ADDR_LO, LEN, LEN payload bytes [, CSUM]
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : a trailing CSUM byte is expected; the 8-bit sum of ADDR_HI,
//               ADDR_LO, LEN, payload and CSUM must be 0, else frame_err.
//   undefined : no CSUM byte, every completed frame gives frame_ok,
//               frame_err is held low.
//
// Ports:
//   clk  in  clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  master modport of rom_image_loader_if (stream in, write port, status)
// Parameters:
//   ADDR_W    ROM address width (<= 16; upper frame address bits dropped)
//   SYNC_BYTE frame start marker
// -----------------------------------------------------------------------------
module rom_image_loader
  import rom_loader_pkg::*;
#(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_image_loader_if.master   bus
);

  state_t            r_state;
  state_t            w_state_next;

  logic [7:0]        r_addr_hi;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [8:0]        r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_ok;
  logic [7:0]        r_ok_count;

  logic              w_in_ready;
  logic              w_xfer;
  logic              w_last_payload;
  logic              w_frame_done;
  logic              w_frame_good;
  logic [15:0]       w_addr_full;

  assign w_in_ready     = (r_state != ST_RESP);
  assign w_xfer         = bus.in_valid && w_in_ready;
  assign w_last_payload = (r_state == ST_DATA) && (r_count == 9'd1);
  assign w_addr_full    = {r_addr_hi, bus.in_data};

  // ---------------------------------------------------------------------------
  // Checksum path
  // ---------------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
  logic       w_csum_clear;
  logic       w_csum_add;
  logic [7:0] w_csum_sum;
  logic [7:0] w_csum_total;
  logic       r_frame_err;

  // Clearing on the sync byte keeps stray bytes seen while hunting out of
  // the sum; every header and payload byte after that is accumulated.
  assign w_csum_clear = w_xfer && (r_state == ST_IDLE);
  assign w_csum_add   = w_xfer && ((r_state == ST_AHI) || (r_state == ST_ALO) ||
                                   (r_state == ST_LEN) || (r_state == ST_DATA));

  rom_loader_csum u_csum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_csum_clear),
    .i_add   (w_csum_add),
    .i_byte  (bus.in_data),
    .o_sum   (w_csum_sum)
  );

  // The CSUM byte itself is folded in combinationally at its acceptance.
  assign w_csum_total = w_csum_sum + bus.in_data;
  assign w_frame_done = w_xfer && (r_state == ST_CSUM);
  assign w_frame_good = (w_csum_total == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_done && !w_frame_good;
    end
  end

  assign bus.frame_err = r_frame_err;
`else
  assign w_frame_done  = w_xfer && w_last_payload;
  assign w_frame_good  = 1'b1;
  assign bus.frame_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && (bus.in_data == SYNC_BYTE)) begin
          w_state_next = ST_AHI;
        end
      end
      ST_AHI: begin
        if (w_xfer) begin
          w_state_next = ST_ALO;
        end
      end
      ST_ALO: begin
        if (w_xfer) begin
          w_state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_xfer) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_xfer && w_last_payload) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_next = ST_CSUM;
`else
          w_state_next = ST_RESP;
`endif
        end
      end
      ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_xfer) begin
          w_state_next = ST_RESP;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: address/count capture, registered write port, result pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hi  <= 8'h00;
      r_cur_addr <= '0;
      r_count    <= 9'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_frame_ok <= 1'b0;
      r_ok_count <= 8'h00;
    end else begin
      r_wr_en    <= 1'b0;
      r_frame_ok <= 1'b0;

      if (w_xfer) begin
        case (r_state)
          ST_AHI: r_addr_hi  <= bus.in_data;
          ST_ALO: r_cur_addr <= w_addr_full[ADDR_W-1:0];
          ST_LEN: r_count    <= len_to_count(bus.in_data);
          ST_DATA: begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_cur_addr;
            r_wr_data  <= bus.in_data;
            // Natural overflow of the ADDR_W-bit register gives the wrap.
            r_cur_addr <= r_cur_addr + 1'b1;
            r_count    <= r_count - 9'd1;
          end
          default: ;
        endcase
      end

      // Result is registered so it is visible during the RESP cycle.
      if (w_frame_done && w_frame_good) begin
        r_frame_ok <= 1'b1;
        if (r_ok_count != 8'hFF) begin
          r_ok_count <= r_ok_count + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.frame_ok = r_frame_ok;
  assign bus.ok_count = r_ok_count;

endmodule

// File: tb/tb_rom_image_loader.sv
module tb_rom_image_loader;
  import rom_loader_pkg::*;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_image_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_ok = 0;

  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          wq_cyc  [$];
  int          ok_pulses  = 0;
  int          err_pulses = 0;
  int          both_high  = 0;
  int          busy_drops = 0;
  bit          track_busy = 1'b0;
  bit          gap_en     = 1'b0;
  logic [7:0]  pl [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: collects write strobes and result pulses away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en === 1'b1) begin
        wq_addr.push_back(bus.wr_addr);
        wq_data.push_back(bus.wr_data);
        wq_cyc.push_back(cyc);
      end
      if (bus.frame_ok === 1'b1) ok_pulses++;
      if (bus.frame_err === 1'b1) err_pulses++;
      if (bus.frame_ok === 1'b1 && bus.frame_err === 1'b1) both_high++;
      if (track_busy && bus.busy !== 1'b1) busy_drops++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- stimulus
  // Called at a negedge; presents a byte until accepted, returns at the
  // negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic maybe_gap();
    if (gap_en && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] addr, input int len, input bit good);
    logic [7:0] sum;
    logic [7:0] lb;
    logic [7:0] cs;
    lb  = len[7:0];
    sum = addr[15:8] + addr[7:0] + lb;
    maybe_gap();
    send_byte(8'hA5);
    track_busy = 1'b1;
    maybe_gap(); send_byte(addr[15:8]);
    maybe_gap(); send_byte(addr[7:0]);
    maybe_gap(); send_byte(lb);
    for (int i = 0; i < len; i++) begin
      maybe_gap();
      send_byte(pl[i]);
      sum = sum + pl[i];
    end
`ifdef LOADER_CHECKSUM_EN
    cs = 8'h00 - sum;
    if (!good) cs = cs + 8'h01;
    maybe_gap();
    send_byte(cs);
`else
    cs = sum;
    if (!good) cs = 8'h00;
`endif
    track_busy = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_cmp++; if (bus.wr_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0000", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    n_cmp++; if ({bus.frame_ok, bus.frame_err, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: ok/err/busy got %b want 000", {bus.frame_ok, bus.frame_err, bus.busy}); end
    n_cmp++; if (bus.ok_count !== 8'h00) begin n_fail++; $display("FAIL reset_ok_count: got %0d want 0", bus.ok_count); end
    rst = 1'b0;
    @(negedge clk);
    exp_ok = 0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) pl[i] = exp_d[i];
    clear_log();
    gap_en = 1'b0;
    send_frame(16'h1234, 3, 1'b1);
    n_cmp++; if (bus.frame_ok !== 1'b1 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: ok/err got %b%b want 10", bus.frame_ok, bus.frame_err); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_resp_ready: got %b want 0", bus.in_ready); end
    @(negedge clk); #1;
    exp_ok = 1;
    n_cmp++; if (bus.frame_ok !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: ok got %b want 0", bus.frame_ok); end
    n_cmp++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 3", wq_addr.size()); end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== 16'h1234 + 16'(i) || wq_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h=%h want %h=%h", i, wq_addr[i], wq_data[i], 16'h1234 + 16'(i), exp_d[i]);
      end
    end
    if (wq_cyc.size() == 3) begin
      n_cmp++;
      if (wq_cyc[1] != wq_cyc[0] + 1 || wq_cyc[2] != wq_cyc[1] + 1) begin
        n_fail++;
        $display("FAIL basic_back_to_back: cycles %0d %0d %0d want consecutive", wq_cyc[0], wq_cyc[1], wq_cyc[2]);
      end
    end
    n_cmp++; if (bus.ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL basic_ok_count: got %0d want %0d", bus.ok_count, exp_ok); end
    $display("test_basic: frame @1234 len 3 writes=%0d ok_count=%0d", wq_addr.size(), bus.ok_count);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_csum_err();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    clear_log();
    send_frame(16'h1234, 3, 1'b0);
    n_cmp++; if (bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL csum_err_pulse: ok/err got %b%b want 01", bus.frame_ok, bus.frame_err); end
    @(negedge clk); #1;
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL csum_err_width: err got %b want 0", bus.frame_err); end
    n_cmp++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL csum_err_nwrites: got %0d want 3", wq_addr.size()); end
    n_cmp++; if (bus.ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL csum_err_ok_count: got %0d want %0d", bus.ok_count, exp_ok); end
    $display("test_csum_err: bad checksum frame writes=%0d err_pulses=%0d", wq_addr.size(), err_pulses);
  endtask
`endif

  task automatic test_wrap();
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    clear_log();
    send_frame(16'hFFFF, 2, 1'b1);
    n_cmp++; if (bus.frame_ok !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: ok got %b want 1", bus.frame_ok); end
    @(negedge clk); #1;
    exp_ok++;
    n_cmp++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      n_cmp++; if (wq_addr[0] !== 16'hFFFF || wq_data[0] !== 8'hAA) begin n_fail++; $display("FAIL wrap_w0: got %h=%h want ffff=aa", wq_addr[0], wq_data[0]); end
      n_cmp++; if (wq_addr[1] !== 16'h0000 || wq_data[1] !== 8'hBB) begin n_fail++; $display("FAIL wrap_w1: got %h=%h want 0000=bb", wq_addr[1], wq_data[1]); end
    end
    $display("test_wrap: frame @ffff len 2 writes=%0d", wq_addr.size());
  endtask

  task automatic test_len256();
    int bad;
    logic [7:0] garbage [3];
    garbage[0] = 8'h00; garbage[1] = 8'hFF; garbage[2] = 8'hA4;
    clear_log();
    for (int i = 0; i < 3; i++) send_byte(garbage[i]);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL garbage_busy: got %b want 0", bus.busy); end
    n_cmp++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL garbage_writes: got %0d want 0", wq_addr.size()); end
    for (int i = 0; i < 256; i++) pl[i] = 8'(i) ^ 8'h5A;
    busy_drops = 0;
    send_frame(16'h4000, 256, 1'b1);
    n_cmp++; if (bus.frame_ok !== 1'b1) begin n_fail++; $display("FAIL len256_pulse: ok got %b want 1", bus.frame_ok); end
    @(negedge clk); #1;
    exp_ok++;
    n_cmp++; if (busy_drops !== 0) begin n_fail++; $display("FAIL len256_busy: low samples %0d want 0", busy_drops); end
    n_cmp++; if (wq_addr.size() !== 256) begin n_fail++; $display("FAIL len256_nwrites: got %0d want 256", wq_addr.size()); end
    bad = 0;
    for (int i = 0; i < wq_addr.size() && i < 256; i++) begin
      if (wq_addr[i] !== 16'h4000 + 16'(i) || wq_data[i] !== (8'(i) ^ 8'h5A)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL len256_content: %0d bad writes want 0", bad); end
    $display("test_len256: writes=%0d first=%h last=%h", wq_addr.size(), wq_addr[0], wq_addr[wq_addr.size()-1]);
  endtask

  task automatic test_reset_mid();
    int okp;
    clear_log();
    for (int i = 0; i < 5; i++) pl[i] = 8'h60 + 8'(i);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h05);
    send_byte(pl[0]); send_byte(pl[1]);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 16'h0000 || bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL midrst_write_port: en/addr/data got %b/%h/%h want 0/0000/00", bus.wr_en, bus.wr_addr, bus.wr_data); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.ok_count !== 8'h00) begin n_fail++; $display("FAIL midrst_status: busy/ready/okc got %b/%b/%0d want 0/1/0", bus.busy, bus.in_ready, bus.ok_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ok = 0;
    okp = ok_pulses;
    send_byte(pl[2]); send_byte(pl[3]); send_byte(pl[4]);
    @(negedge clk); #1;
    n_cmp++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL midrst_writes: got %0d want 2", wq_addr.size()); end
    n_cmp++; if (ok_pulses !== okp || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse: pulses %0d busy %b want %0d 0", ok_pulses, bus.busy, okp); end
    clear_log();
    pl[0] = 8'hC1; pl[1] = 8'hC2;
    send_frame(16'h0100, 2, 1'b1);
    @(negedge clk); #1;
    exp_ok++;
    n_cmp++; if (wq_addr.size() !== 2 || wq_addr[0] !== 16'h0100 || wq_data[1] !== 8'hC2) begin n_fail++; $display("FAIL midrst_recover: n=%0d want 2 @0100 second data c2", wq_addr.size()); end
    n_cmp++; if (bus.ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL midrst_ok_count: got %0d want %0d", bus.ok_count, exp_ok); end
    $display("test_reset_mid: recovered, ok_count=%0d", bus.ok_count);
  endtask

  task automatic test_random();
    logic [15:0] a;
    int len;
    int bad;
    gap_en = 1'b1;
    for (int f = 0; f < 300; f++) begin
      a   = 16'($urandom);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
      clear_log();
      send_frame(a, len, 1'b1);
      n_cmp++; if (bus.frame_ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_pulse: ok got %b want 1", f, bus.frame_ok); end
      @(negedge clk); #1;
      if (exp_ok < 255) exp_ok++;
      bad = (wq_addr.size() != len) ? 1 : 0;
      for (int i = 0; i < len && i < wq_addr.size(); i++) begin
        if (wq_addr[i] !== a + 16'(i) || wq_data[i] !== pl[i]) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_writes: %0d errors (n=%0d want %0d)", f, bad, wq_addr.size(), len); end
      n_cmp++; if (bus.ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL rand%0d_ok_count: got %0d want %0d", f, bus.ok_count, exp_ok); end
      $display("rand frame %0d: addr=%h len=%0d writes=%0d ok_count=%0d", f, a, len, wq_addr.size(), bus.ok_count);
    end
    gap_en = 1'b0;
    n_cmp++; if (bus.ok_count !== 8'd255) begin n_fail++; $display("FAIL ok_count_saturate: got %0d want 255", bus.ok_count); end
    n_cmp++; if (both_high !== 0) begin n_fail++; $display("FAIL ok_err_exclusive: both high %0d times want 0", both_high); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
`ifdef LOADER_CHECKSUM_EN
    test_csum_err();
`endif
    test_wrap();
    test_len256();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
